sram_port_arbiter: RTL

Time-division controller for the single-port pixel SRAM: shares the 20-bit address / 3-bit data port between the VGA scan-out reader, the cursor/paint writer and a built-in full-screen clear engine. Sits between the 25 MHz pixel logic and the SRAM pins, running on the 50 MHz master clock so that every pixel period contains one read slot and one write slot. Paint writes are buffered in a small FIFO so the writer never has to be co-timed with the beam position.

---
 rtl/sram_port_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Time-division arbiter for the single-port pixel SRAM: alternating read/write slots,
// paint-write FIFO and full-screen clear engine. Optional: SRAM_ARB_BLANK_WRITE_EN.
module sram_port_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int XMAX       = 640,
   parameter int YMAX       = 480
) (
   input  logic        master_clk,
   input  logic        rst,
   output logic        slot_phase,
   input  logic        vid_req,
   input  logic [19:0] vid_addr,
   output logic [2:0]  vid_data,
   output logic        vid_valid,
   input  logic        wr_req,
   input  logic [19:0] wr_addr,
   input  logic [2:0]  wr_data,
   output logic        wr_ready,
   input  logic        clr_start,
   input  logic [2:0]  clr_color,
   output logic        clr_busy,
   output logic [19:0] sram_addr,
   output logic [2:0]  sram_wdata,
   input  logic [2:0]  sram_rdata,
   output logic        sram_we
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic              phase_q, phase_d;
   logic [2:0]        vid_data_q, vid_data_d;
   logic              vid_valid_q, vid_valid_d;
   logic [19:0]       addr_hold_q, addr_hold_d;

   logic [19:0]       fifo_addr_q [FIFO_DEPTH];
   logic [19:0]       fifo_addr_d [FIFO_DEPTH];
   logic [2:0]        fifo_data_q [FIFO_DEPTH];
   logic [2:0]        fifo_data_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic              clr_busy_q, clr_busy_d;
   logic [9:0]        cx_q, cx_d;
   logic [9:0]        cy_q, cy_d;
   logic [2:0]        clr_color_q, clr_color_d;

   logic              fifo_empty, fifo_full;
   logic              read_slot, write_slot;
   logic              clr_wr, fifo_wr, push;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign read_slot  = ~phase_q & vid_req;

`ifdef SRAM_ARB_BLANK_WRITE_EN
   // An idle read slot doubles as a write slot during blanking.
   assign write_slot = phase_q | ~vid_req;
`else
   assign write_slot = phase_q;
`endif

   assign clr_wr  = write_slot & clr_busy_q;
   assign fifo_wr = write_slot & ~clr_busy_q & ~fifo_empty;
   assign push    = wr_req & ~fifo_full;

   assign slot_phase = phase_q;
   assign vid_data   = vid_data_q;
   assign vid_valid  = vid_valid_q;
   assign wr_ready   = ~fifo_full;
   assign clr_busy   = clr_busy_q;

   always_comb begin
      sram_we    = 1'b1;
      sram_addr  = addr_hold_q;
      sram_wdata = 3'b000;
      if (read_slot) begin
         sram_addr = vid_addr;
      end else if (clr_wr) begin
         sram_we    = 1'b0;
         sram_addr  = {cx_q, cy_q};
         sram_wdata = clr_color_q;
      end else if (fifo_wr) begin
         sram_we    = 1'b0;
         sram_addr  = fifo_addr_q[rd_ptr_q];
         sram_wdata = fifo_data_q[rd_ptr_q];
      end
   end

   always_comb begin
      phase_d     = ~phase_q;
      addr_hold_d = sram_addr;
      vid_valid_d = read_slot;
      vid_data_d  = read_slot ? sram_rdata : vid_data_q;

      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push) begin
         fifo_addr_d[wr_ptr_q] = wr_addr;
         fifo_data_d[wr_ptr_q] = wr_data;
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (fifo_wr) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, fifo_wr})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      clr_busy_d  = clr_busy_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      clr_color_d = clr_color_q;
      // A new start always wins, restarting the fill from the origin.
      if (clr_start) begin
         clr_busy_d  = 1'b1;
         cx_d        = '0;
         cy_d        = '0;
         clr_color_d = clr_color;
      end else if (clr_wr) begin
         if (cx_q == 10'(XMAX - 1)) begin
            cx_d = '0;
            if (cy_q == 10'(YMAX - 1)) begin
               cy_d       = '0;
               clr_busy_d = 1'b0;
            end else begin
               cy_d = cy_q + 10'd1;
            end
         end else begin
            cx_d = cx_q + 10'd1;
         end
      end
   end

   always_ff @(posedge master_clk or negedge rst) begin
      if (!rst) begin
         phase_q     <= 1'b0;
         vid_data_q  <= '0;
         vid_valid_q <= 1'b0;
         addr_hold_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         clr_busy_q  <= 1'b0;
         cx_q        <= '0;
         cy_q        <= '0;
         clr_color_q <= '0;
      end else begin
         phase_q     <= phase_d;
         vid_data_q  <= vid_data_d;
         vid_valid_q <= vid_valid_d;
         addr_hold_q <= addr_hold_d;
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         clr_busy_q  <= clr_busy_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         clr_color_q <= clr_color_d;
      end
   end

endmodule
